// File: rtl/dat_fill_seq.sv
// dat_fill_seq: fills DAT entries 0..last with an identity page->bank map, optionally reads them back,
// and yields every cycle to the CPU, which owns the DAT SRAM whenever cpu_req is high.
module dat_fill_seq #(
   parameter int         ADDR_WIDTH = 15,
   parameter logic [4:0] BANK_BASE  = 5'b00000,
   parameter logic [7:0] FILL_HI    = 8'h00,
   parameter bit         VERIFY_EN  = 1'b1
) (
   input  logic                  e,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] last_addr,
   input  logic                  cpu_req,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [15:0]           cpu_wdata,
   input  logic                  cpu_we_l,
   input  logic                  cpu_we_h,
   input  logic [15:0]           dat_rd_data,
   output logic [ADDR_WIDTH-1:0] dat_addr,
   output logic [15:0]           dat_wdata,
   output logic                  dat_we_l,
   output logic                  dat_we_h,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] err_addr
);
   typedef enum logic [1:0] {IDLE, FILL, VERIFY} state_t;
   state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, last_q, last_d, err_addr_q, err_addr_d;
   logic error_q, error_d, done_q, done_d;
   logic [15:0] pat;
   logic at_last;
   assign pat = {FILL_HI, BANK_BASE, ptr_q[2:0]};
   assign at_last = ptr_q == last_q;
   assign done = done_q;
   assign error = error_q;
   assign err_addr = err_addr_q;

   always_ff @(posedge e) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q <= '0;
         last_q <= '0;
         error_q <= 1'b0;
         err_addr_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         last_q <= last_d;
         error_q <= error_d;
         err_addr_q <= err_addr_d;
         done_q <= done_d;
      end
   end

   // end-of-range test precedes the increment, so ptr never wraps even at all-ones
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      last_d = last_q;
      error_d = error_q;
      err_addr_d = err_addr_q;
      done_d = 1'b0;
      if (!cpu_req)
         case (state_q)
            IDLE: if (start) begin
               state_d = FILL;
               ptr_d = '0;
               last_d = last_addr;
               error_d = 1'b0;
               err_addr_d = '0;
            end
            FILL: begin
               ptr_d = at_last ? '0 : ptr_q + 1'b1;
               if (at_last) begin
                  state_d = VERIFY_EN ? VERIFY : IDLE;
                  done_d = !VERIFY_EN;
               end
            end
            VERIFY: begin
               if (dat_rd_data != pat && !error_q) begin
                  error_d = 1'b1;
                  err_addr_d = ptr_q;
               end
               ptr_d = at_last ? '0 : ptr_q + 1'b1;
               if (at_last) begin
                  state_d = IDLE;
                  done_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
   end

   always_comb begin
      dat_addr = (cpu_req || state_q == IDLE) ? cpu_addr : ptr_q;
      dat_wdata = (cpu_req || state_q == IDLE) ? cpu_wdata : pat;
      dat_we_l = !reset && (cpu_req ? cpu_we_l : state_q == FILL);
      dat_we_h = !reset && (cpu_req ? cpu_we_h : state_q == FILL);
      busy = state_q != IDLE;
   end
endmodule

// File: tb/tb_dat_fill_seq.sv
// tb_dat_fill_seq: directed bench; instance a is checked every cycle against a queue-of-accesses model,
// instance b covers the no-verify single-entry case, instance c the full 32K range.
module tb_dat_fill_seq;
   localparam int AW = 15;
   logic e = 1'b0;
   logic reset = 1'b1;
   always #5 e = ~e;

   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, corrupt = 1'b0, zero = 1'b0;
   logic [AW-1:0] last_addr = '0, cpu_addr = '0, zaddr = '0;
   logic [15:0] cpu_wdata = '0, zdata = '0;
   logic cpu_req = 1'b0, cpu_we_l = 1'b0, cpu_we_h = 1'b0;

   logic [AW-1:0] addr_a, addr_b, addr_c, err_addr_a, err_addr_b, err_addr_c;
   logic [15:0] wdata_a, wdata_b, wdata_c, rd_a, rd_c;
   logic we_l_a, we_h_a, busy_a, done_a, error_a;
   logic we_l_b, we_h_b, busy_b, done_b, error_b;
   logic we_l_c, we_h_c, busy_c, done_c, error_c;

   logic [15:0] mem_a [32768];
   logic [15:0] mem_c [32768];
   int wr_cnt [16];
   int wcnt_c = 0;
   logic [AW-1:0] last_wa = '0;
   logic [15:0] last_wd = '0;
   int vec = 0, bad = 0;

   dat_fill_seq dut_a (.e(e), .reset(reset), .start(start_a), .last_addr(last_addr), .cpu_req(cpu_req),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we_l(cpu_we_l), .cpu_we_h(cpu_we_h),
      .dat_rd_data(rd_a), .dat_addr(addr_a), .dat_wdata(wdata_a), .dat_we_l(we_l_a), .dat_we_h(we_h_a),
      .busy(busy_a), .done(done_a), .error(error_a), .err_addr(err_addr_a));

   dat_fill_seq #(.VERIFY_EN(1'b0)) dut_b (.e(e), .reset(reset), .start(start_b), .last_addr(last_addr),
      .cpu_req(zero), .cpu_addr(zaddr), .cpu_wdata(zdata), .cpu_we_l(zero), .cpu_we_h(zero),
      .dat_rd_data(zdata), .dat_addr(addr_b), .dat_wdata(wdata_b), .dat_we_l(we_l_b), .dat_we_h(we_h_b),
      .busy(busy_b), .done(done_b), .error(error_b), .err_addr(err_addr_b));

   dat_fill_seq #(.BANK_BASE(5'b00001)) dut_c (.e(e), .reset(reset), .start(start_c), .last_addr(last_addr),
      .cpu_req(zero), .cpu_addr(zaddr), .cpu_wdata(zdata), .cpu_we_l(zero), .cpu_we_h(zero),
      .dat_rd_data(rd_c), .dat_addr(addr_c), .dat_wdata(wdata_c), .dat_we_l(we_l_c), .dat_we_h(we_h_c),
      .busy(busy_c), .done(done_c), .error(error_c), .err_addr(err_addr_c));

   // SRAM models; instance a can be made to return a bad word at entries 9 and 12
   assign rd_a = (corrupt && (addr_a == 15'd9 || addr_a == 15'd12)) ? 16'h00FF : mem_a[addr_a];
   assign rd_c = mem_c[addr_c];

   initial for (int i = 0; i < 16; i++) wr_cnt[i] = 0;

   always @(posedge e) begin
      if (we_l_a) mem_a[addr_a][7:0] <= wdata_a[7:0];
      if (we_h_a) mem_a[addr_a][15:8] <= wdata_a[15:8];
      if ((we_l_a || we_h_a) && addr_a < 15'd16) wr_cnt[addr_a[3:0]] <= wr_cnt[addr_a[3:0]] + 1;
      if (we_l_c) begin
         mem_c[addr_c] <= wdata_c;
         wcnt_c <= wcnt_c + 1;
         last_wa <= addr_c;
         last_wd <= wdata_c;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] pat(input int a, input int bank);
      return 16'(bank * 8 + a % 8);
   endfunction

   // model of instance a: an accepted start queues N writes then N reads; each idle CPU cycle retires one
   int q_addr[$];
   bit q_wr[$];
   bit m_done = 0, m_err = 0;
   int m_err_addr = 0;
   always @(negedge e) begin : model
      int a;
      bit w;
      if (reset) begin
         chk("reset_strobes", {we_h_a, we_l_a}, 0);
         q_addr.delete();
         q_wr.delete();
         m_done = 0;
         m_err = 0;
         m_err_addr = 0;
      end else begin
         chk("busy", busy_a, q_addr.size() != 0);
         chk("done", done_a, m_done);
         chk("error", error_a, m_err);
         chk("err_addr", err_addr_a, m_err_addr);
         if (cpu_req) begin
            chk("cpu_addr", addr_a, cpu_addr);
            chk("cpu_wdata", wdata_a, cpu_wdata);
            chk("cpu_we", {we_h_a, we_l_a}, {cpu_we_h, cpu_we_l});
            m_done = 0;
         end else if (q_addr.size() != 0) begin
            a = q_addr.pop_front();
            w = q_wr.pop_front();
            chk("eng_addr", addr_a, a);
            chk("eng_we", {we_h_a, we_l_a}, w ? 3 : 0);
            if (w) chk("eng_wdata", wdata_a, pat(a, 0));
            else if (rd_a != pat(a, 0) && !m_err) begin
               m_err = 1;
               m_err_addr = a;
            end
            m_done = q_addr.size() == 0;
         end else begin
            chk("idle_addr", addr_a, cpu_addr);
            chk("idle_we", {we_h_a, we_l_a}, 0);
            m_done = 0;
            if (start_a) begin
               for (int i = 0; i <= int'(last_addr); i++) begin q_addr.push_back(i); q_wr.push_back(1); end
               for (int i = 0; i <= int'(last_addr); i++) begin q_addr.push_back(i); q_wr.push_back(0); end
               m_err = 0;
               m_err_addr = 0;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge e);
      #1;
   endtask

   task automatic go_a(input logic [AW-1:0] la);
      last_addr = la;
      start_a = 1'b1;
      cyc();
      start_a = 1'b0;
   endtask

   // lat = edges after the one that accepted start until done is seen; pre = edges already elapsed
   task automatic run_a(input int pre, output int lat, output int bcnt);
      lat = -1;
      bcnt = busy_a ? 1 : 0;
      for (int k = pre + 1; k <= 200; k++) begin
         cyc();
         if (busy_a) bcnt++;
         if (done_a) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat, bcnt, w5;
      repeat (3) cyc();
      reset = 1'b0;
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_error", error_a, 0);
      chk("rst_err_addr", err_addr_a, 0);
      chk("rst_busy_c", busy_c, 0);
      cyc();

      // plain fill + verify of 16 entries
      go_a(15'd15);
      run_a(0, lat, bcnt);
      chk("t1_latency", lat, 32);
      chk("t1_busy_cycles", bcnt, 32);
      chk("t1_error", error_a, 0);
      chk("t1_mem13", mem_a[13], 16'h0005);
      chk("t1_mem15", mem_a[15], 16'h0007);
      cyc();
      chk("t1_done_once", done_a, 0);

      // CPU steals 3 cycles at ptr=5
      w5 = wr_cnt[5];
      go_a(15'd15);
      repeat (5) cyc();
      cpu_req = 1'b1;
      cpu_addr = 15'h2AAA;
      cpu_wdata = 16'hBEEF;
      #1;
      chk("t2_cpu_addr", addr_a, 15'h2AAA);
      chk("t2_cpu_we", we_l_a, 0);
      repeat (3) cyc();
      cpu_req = 1'b0;
      run_a(8, lat, bcnt);
      chk("t2_latency", lat, 35);
      chk("t2_entry5_writes", wr_cnt[5] - w5, 1);
      cyc();

      // corrupted readback at entries 9 and 12
      corrupt = 1'b1;
      go_a(15'd15);
      run_a(0, lat, bcnt);
      chk("t3_latency", lat, 32);
      chk("t3_error", error_a, 1);
      chk("t3_err_addr", err_addr_a, 9);
      corrupt = 1'b0;
      cyc();
      chk("t3_error_sticky", error_a, 1);
      chk("t3_err_addr_sticky", err_addr_a, 9);

      // reset during FILL at ptr=7
      go_a(15'd15);
      repeat (7) cyc();
      chk("t5_pre_we", we_l_a, 1);
      chk("t5_pre_addr", addr_a, 7);
      reset = 1'b1;
      #1;
      chk("t5_reset_we_l", we_l_a, 0);
      chk("t5_reset_we_h", we_h_a, 0);
      cyc();
      reset = 1'b0;
      chk("t5_busy", busy_a, 0);
      chk("t5_error_cleared", error_a, 0);
      for (int i = 0; i < 3; i++) begin
         chk("t5_no_done", done_a, 0);
         cyc();
      end
      cpu_req = 1'b1;
      cpu_addr = 15'h0042;
      cpu_wdata = 16'h0100;
      cpu_we_l = 1'b1;
      cpu_we_h = 1'b1;
      #1;
      chk("t5_cpu_wdata", wdata_a, 16'h0100);
      chk("t5_cpu_we", {we_h_a, we_l_a}, 3);
      cyc();
      cpu_req = 1'b0;
      cpu_we_l = 1'b0;
      cpu_we_h = 1'b0;
      chk("t5_mem", mem_a[15'h0042], 16'h0100);

      // single entry, no verify pass, back-to-back start in the done cycle
      last_addr = 15'd0;
      start_b = 1'b1;
      cyc();
      start_b = 1'b0;
      chk("t4_we", {we_h_b, we_l_b}, 3);
      chk("t4_addr", addr_b, 0);
      chk("t4_wdata", wdata_b, 16'h0000);
      chk("t4_busy", busy_b, 1);
      cyc();
      chk("t4_done", done_b, 1);
      chk("t4_idle", busy_b, 0);
      start_b = 1'b1;
      cyc();
      start_b = 1'b0;
      chk("t4_restart_busy", busy_b, 1);
      chk("t4_restart_we", we_l_b, 1);
      chk("t4_restart_nodone", done_b, 0);
      cyc();
      chk("t4_done2", done_b, 1);
      chk("t4_error", error_b, 0);

      // full 32K range with bank base 1
      last_addr = 15'h7FFF;
      start_c = 1'b1;
      cyc();
      start_c = 1'b0;
      lat = -1;
      for (int k = 1; k <= 70000; k++) begin
         cyc();
         if (done_c) begin
            lat = k;
            break;
         end
      end
      chk("t6_latency", lat, 65536);
      chk("t6_writes", wcnt_c, 32768);
      chk("t6_last_addr", last_wa, 15'h7FFF);
      chk("t6_last_data", last_wd, 16'h000F);
      chk("t6_mem0", mem_c[0], 16'h0008);
      chk("t6_error", error_c, 0);
      cyc();
      chk("t6_idle", busy_c, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
